csr_uart_rx_fifo: RTL and testbench

//  CSR-bus responder: buffered UART receiver (8N1) for boards whose CPU cannot poll per character.

---
 rtl/csr_uart_rx_fifo_pkg.sv | 33 +++
 rtl/csr_uart_rx_fifo_if.sv | 12 +
 rtl/csr_uart_rx_fifo_uart_rx_core.sv | 126 ++++++++++++
 rtl/csr_uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_csr_uart_rx_fifo.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_uart_rx_fifo_pkg.sv
// Shared definitions for the buffered UART receiver CSR block:
// CSR modify encodings, status field positions and the status packer.
package csr_uart_rx_fifo_pkg;

   typedef enum logic [2:0] {
      MOD_NONE  = 3'b000,
      MOD_WRITE = 3'b001,
      MOD_SET   = 3'b010,
      MOD_CLEAR = 3'b100
   } csr_mod_t;

   localparam int STAT_OVERRUN   = 16;
   localparam int STAT_FRAME_ERR = 17;
   localparam int STAT_IRQ_EN    = 24;

   typedef struct packed {
      logic [7:0] level;
      logic       overrun;
      logic       frame_err;
      logic       irq_en;
   } status_t;

   function automatic logic [31:0] pack_status(input status_t s);
      logic [31:0] w;
      w                 = '0;
      w[7:0]            = s.level;
      w[STAT_OVERRUN]   = s.overrun;
      w[STAT_FRAME_ERR] = s.frame_err;
      w[STAT_IRQ_EN]    = s.irq_en;
      return w;
   endfunction

endpackage

// File: rtl/csr_uart_rx_fifo_if.sv
// CSR bus bundle between the pipeline (master) and a CSR peripheral (slave).
interface csr_uart_rx_fifo_if;
   logic        read;
   logic [2:0]  modify;
   logic [31:0] wdata;
   logic [11:0] addr;
   logic [31:0] rdata;
   logic        valid;

   modport master (output read, modify, wdata, addr, input rdata, valid);
   modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_uart_rx_fifo_uart_rx_core.sv
// 8N1 UART receive core: 2-flop synchroniser, bit-timing down-counter and
// frame FSM. Emits a one-cycle strobe with the byte on a good stop bit, or a
// one-cycle frame_err pulse on a bad one.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a falling edge on the synchronised line
//  S_START | half a bit in; confirm start bit still low, else glitch
//  S_DATA  | sample one data bit per DIV cycles, LSB first
//  S_STOP  | sample stop bit; high -> strobe, low -> frame_err
//
// The synchroniser resets low and the detector stays disarmed until the line
// has been seen high, so a frame already in flight at reset release is
// ignored until the line goes idle.
module uart_rx_core
   import csr_uart_rx_fifo_pkg::*;
#(
   parameter int DIV = 868
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic [7:0] data,
   output logic       strobe,
   output logic       frame_err
);

   localparam int CW = $clog2(DIV + 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } rx_state_t;

   rx_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shift, shift_nx;
   logic          rx_meta, rx_sync, armed;

   // Synchronise the asynchronous line and arm once it has been seen idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta <= 1'b0;
         rx_sync <= 1'b0;
         armed   <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         armed   <= armed | rx_sync;
      end
   end

   // Frame state, bit timer, bit index and shift register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         shift   <= shift_nx;
      end
   end

   // Next-state, timer reload and byte/error strobes.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      strobe     = 1'b0;
      frame_err  = 1'b0;
      case (state)
         S_IDLE: begin
            if (armed && !rx_sync) begin
               state_nx = S_START;
               cnt_nx   = CNT_HALF;
            end
         end
         S_START: begin
            if (cnt == '0) begin
               if (!rx_sync) begin
                  state_nx   = S_DATA;
                  cnt_nx     = CNT_FULL;
                  bit_idx_nx = '0;
               end else begin
                  state_nx = S_IDLE;
               end
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt == '0) begin
               shift_nx   = {rx_sync, shift[7:1]};
               cnt_nx     = CNT_FULL;
               bit_idx_nx = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_nx = S_STOP;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_STOP: begin
            if (cnt == '0) begin
               if (rx_sync) strobe = 1'b1;
               else         frame_err = 1'b1;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign data = shift;

endmodule

// File: rtl/csr_uart_rx_fifo.sv
// Buffered 8N1 UART receiver on the CSR bus.
//   BASE_ADDR   : data CSR, read pops one byte (all ones when empty)
//   BASE_ADDR+1 : status/control {irq_en[24], frame_err[17], overrun[16], level[7:0]}
// Optional build macro UART_RX_IRQ_EN adds the irq_en control bit and a
// registered level-based interrupt; without it irq is tied low.
module csr_uart_rx_fifo
   import csr_uart_rx_fifo_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR  = 12'hBC4,
   parameter int          CLOCK_RATE = 100_000_000,
   parameter int          BAUD_RATE  = 115200,
   parameter int          FIFO_AW    = 4
) (
   input  logic              clk,
   input  logic              rstn,
   csr_uart_rx_fifo_if.slave bus,
   input  logic              rx,
   output logic              irq
);

   localparam int DIV   = CLOCK_RATE / BAUD_RATE;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [11:0]      STAT_ADDR = BASE_ADDR + 12'd1;
   localparam logic [FIFO_AW:0] FULL_LVL  = {1'b1, {FIFO_AW{1'b0}}};

   logic [7:0]       rx_byte;
   logic             rx_strobe, rx_ferr;
   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr, level;
   logic             empty, full, data_hit, stat_hit, write_op, access;
   logic             pop, push, drop, ovr_clr, ferr_clr;
   logic             overrun, frame_err, irq_en;
   logic [31:0]      rd_val;
   status_t          status;

   uart_rx_core #(.DIV(DIV)) u_core (
      .clk       (clk),
      .rstn      (rstn),
      .rx        (rx),
      .data      (rx_byte),
      .strobe    (rx_strobe),
      .frame_err (rx_ferr)
   );

   assign level    = wr_ptr - rd_ptr;
   assign empty    = (level == '0);
   assign full     = (level == FULL_LVL);
   assign data_hit = (bus.addr == BASE_ADDR);
   assign stat_hit = (bus.addr == STAT_ADDR);
   assign write_op = (bus.modify == MOD_WRITE) || (bus.modify == MOD_SET) ||
                     (bus.modify == MOD_CLEAR);
   assign access   = bus.read || write_op;

   // A pop frees a slot in the same cycle, so a push at full still lands then.
   assign pop  = bus.read && data_hit && !empty;
   assign push = rx_strobe && (!full || pop);
   assign drop = rx_strobe && full && !pop;

   // Sticky flags clear only through write or clear ops carrying a 1.
   assign ovr_clr  = stat_hit && ((bus.modify == MOD_WRITE) || (bus.modify == MOD_CLEAR)) &&
                     bus.wdata[STAT_OVERRUN];
   assign ferr_clr = stat_hit && ((bus.modify == MOD_WRITE) || (bus.modify == MOD_CLEAR)) &&
                     bus.wdata[STAT_FRAME_ERR];

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= rx_byte;
   end

   // FIFO pointers, one extra bit to tell full from empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sticky error flags; a new event wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= (overrun & ~ovr_clr) | drop;
         frame_err <= (frame_err & ~ferr_clr) | rx_ferr;
      end
   end

`ifdef UART_RX_IRQ_EN
   logic unused_wdata;
   assign unused_wdata = ^{bus.wdata[31:25], bus.wdata[23:18], bus.wdata[15:0]};

   // Interrupt enable obeys write/set/clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         irq_en <= 1'b0;
      end else if (stat_hit) begin
         if (bus.modify == MOD_WRITE)
            irq_en <= bus.wdata[STAT_IRQ_EN];
         else if ((bus.modify == MOD_SET) && bus.wdata[STAT_IRQ_EN])
            irq_en <= 1'b1;
         else if ((bus.modify == MOD_CLEAR) && bus.wdata[STAT_IRQ_EN])
            irq_en <= 1'b0;
      end
   end

   // Level interrupt, registered from the current FIFO level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) irq <= 1'b0;
      else       irq <= irq_en & ~empty;
   end
`else
   logic unused_wdata;
   assign unused_wdata = ^{bus.wdata[31:18], bus.wdata[15:0]};
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   // Read value mux for the addressed CSR.
   always_comb begin
      status           = '0;
      status.level     = 8'(level);
      status.overrun   = overrun;
      status.frame_err = frame_err;
      status.irq_en    = irq_en;
      rd_val           = '0;
      if (data_hit)
         rd_val = empty ? 32'hFFFF_FFFF : {24'b0, mem[rd_ptr[FIFO_AW-1:0]]};
      else if (stat_hit)
         rd_val = pack_status(status);
   end

   // Registered response, zero unless this block was addressed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.rdata <= '0;
         bus.valid <= 1'b0;
      end else begin
         bus.valid <= access && (data_hit || stat_hit);
         bus.rdata <= (access && (data_hit || stat_hit)) ? rd_val : 32'h0;
      end
   end

endmodule

// File: tb/tb_csr_uart_rx_fifo.sv
// Bench for csr_uart_rx_fifo at DIV=10, four-entry FIFO. A queue-based model
// tracks the bytes and flags the CSRs should report.
module tb_csr_uart_rx_fifo;

   localparam logic [11:0] BASE = 12'hBC4;
   localparam logic [11:0] STAT = 12'hBC5;
   localparam int DEPTH = 4;
`ifdef UART_RX_IRQ_EN
   localparam bit HAS_IRQ = 1'b1;
`else
   localparam bit HAS_IRQ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic rx = 1'b1;
   logic irq;

   csr_uart_rx_fifo_if bus();

   csr_uart_rx_fifo #(
      .BASE_ADDR  (BASE),
      .CLOCK_RATE (100),
      .BAUD_RATE  (10),
      .FIFO_AW    (2)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus),
      .rx   (rx),
      .irq  (irq)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   logic [7:0] q[$];
   bit m_ovr = 0, m_ferr = 0, m_ien = 0;
   logic [31:0] rd;
   logic vl;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_status();
      return (m_ien ? 32'h0100_0000 : 32'h0) | (m_ferr ? 32'h0002_0000 : 32'h0) |
             (m_ovr ? 32'h0001_0000 : 32'h0) | 32'(q.size());
   endfunction

   function automatic logic [31:0] exp_irq();
      return 32'(HAS_IRQ && m_ien && (q.size() != 0));
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int c);
      int i;
      i = c / 10;
      if (i == 0) return 1'b0;
      if (i == 9) return stop;
      return b[i-1];
   endfunction

   task automatic csr(input logic r, input logic [2:0] md, input logic [11:0] a,
                      input logic [31:0] wd, output logic [31:0] rdv, output logic v);
      bus.read = r; bus.modify = md; bus.addr = a; bus.wdata = wd;
      tick();
      rdv = bus.rdata; v = bus.valid;
      bus.read = 1'b0; bus.modify = 3'b000; bus.wdata = 32'h0;
   endtask

   // Read the data CSR and compare against the model head (or all ones).
   task automatic pop_check(input string tag);
      logic [31:0] e;
      e = (q.size() == 0) ? 32'hFFFF_FFFF : {24'b0, q[0]};
      if (q.size() != 0) void'(q.pop_front());
      csr(1'b1, 3'b000, BASE, 32'h0, rd, vl);
      check(tag, rd, e);
   endtask

   task automatic status_check(input string tag);
      csr(1'b1, 3'b000, STAT, 32'h0, rd, vl);
      check(tag, rd, exp_status());
   endtask

   // One full 8N1 frame; optionally pops the data CSR in the push cycle.
   task automatic send(input logic [7:0] b, input logic stop, input bit pop_at_push,
                       output logic [31:0] pop_data);
      pop_data = 32'h0;
      for (int c = 0; c < 100; c++) begin
         rx = frame_bit(b, stop, c);
         bus.read = pop_at_push && (c == 98);
         bus.addr = BASE;
         tick();
         if (pop_at_push && (c == 98)) pop_data = bus.rdata;
      end
      bus.read = 1'b0;
      rx = 1'b1;
      if (!stop) m_ferr = 1;
      else if (pop_at_push) begin
         if (q.size() != 0) void'(q.pop_front());
         q.push_back(b);
      end else if (q.size() == DEPTH) m_ovr = 1;
      else q.push_back(b);
   endtask

   logic [31:0] pd;
   logic [7:0]  bytes[4];
   logic [7:0]  rb;

   initial begin
      bus.read = 1'b0; bus.modify = 3'b000; bus.wdata = 32'h0; bus.addr = 12'h0;
      repeat (3) tick();
      check("reset_rdata", bus.rdata, 32'h0);
      check("reset_valid", 32'(bus.valid), 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      rstn = 1'b1;
      repeat (4) tick();
      csr(1'b1, 3'b000, STAT, 32'h0, rd, vl);
      check("reset_status", rd, 32'h0);
      check("status_valid", 32'(vl), 32'h1);
      pop_check("reset_empty_read");
      csr(1'b1, 3'b000, BASE + 12'd2, 32'h0, rd, vl);
      check("miss_rdata", rd, 32'h0);
      check("miss_valid", 32'(vl), 32'h0);

      // single byte
      send(8'hA5, 1'b1, 1'b0, pd);
      repeat (2) tick();
      pop_check("t1_byte");
      pop_check("t1_empty");

      // overrun on the fifth byte
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, pd);
      csr(1'b1, 3'b000, STAT, 32'h0, rd, vl);
      check("t2_status", rd, 32'h0001_0004);
      for (int i = 0; i < 5; i++) pop_check("t2_drain");
      csr(1'b0, 3'b001, STAT, 32'h0001_0000, rd, vl);
      m_ovr = 0;
      status_check("t2_ovr_cleared");

      // frame error and flag clear rules
      send(8'h3C, 1'b0, 1'b0, pd);
      csr(1'b1, 3'b000, STAT, 32'h0, rd, vl);
      check("t3_status", rd, 32'h0002_0000);
      csr(1'b0, 3'b010, STAT, 32'h0003_0000, rd, vl);
      status_check("t3_set_no_effect");
      csr(1'b0, 3'b001, STAT, 32'h0, rd, vl);
      status_check("t3_write0_no_effect");
      csr(1'b0, 3'b100, STAT, 32'h0002_0000, rd, vl);
      m_ferr = 0;
      csr(1'b1, 3'b000, STAT, 32'h0, rd, vl);
      check("t3_cleared", rd, 32'h0);

      // short glitch is rejected, then a real byte still decodes
      rx = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
      rx = 1'b1;
      repeat (30) tick();
      status_check("t4_glitch_status");
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'b1, 1'b0, pd);
      pop_check("t4_after_glitch");

      // pop exactly as a push lands on a full FIFO
      for (int i = 0; i < 4; i++) begin
         bytes[i] = 8'($urandom_range(0, 255));
         send(bytes[i], 1'b1, 1'b0, pd);
      end
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'b1, 1'b1, pd);
      check("t5_pop_data", pd, {24'b0, bytes[0]});
      csr(1'b1, 3'b000, STAT, 32'h0, rd, vl);
      check("t5_status", rd, 32'h0000_0004);
      for (int i = 0; i < 5; i++) pop_check("t5_order");

      // interrupt enable and level interrupt
      csr(1'b0, 3'b010, STAT, 32'h0100_0000, rd, vl);
      if (HAS_IRQ) m_ien = 1;
      status_check("t6_irq_en");
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'b1, 1'b0, pd);
      repeat (2) tick();
      check("t6_irq_high", 32'(irq), exp_irq());
      pop_check("t6_pop");
      tick();
      check("t6_irq_low", 32'(irq), 32'h0);
      send(8'($urandom_range(0, 255)), 1'b1, 1'b0, pd);
      repeat (2) tick();
      check("t6_irq_again", 32'(irq), exp_irq());

      // reset mid-DATA flushes and the in-flight frame is ignored
      for (int c = 0; c < 100; c++) begin
         rx = frame_bit(8'h00, 1'b1, c);
         if (c == 35) rstn = 1'b0;
         if (c == 40) rstn = 1'b1;
         tick();
         if (c == 36) begin
            check("t6_rst_irq", 32'(irq), 32'h0);
            check("t6_rst_rdata", bus.rdata, 32'h0);
         end
      end
      rx = 1'b1;
      q.delete(); m_ovr = 0; m_ferr = 0; m_ien = 0;
      repeat (30) tick();
      status_check("t6_after_reset");
      check("t6_after_reset_irq", 32'(irq), 32'h0);

      // randomized bursts against the model
      for (int r = 0; r < 6; r++) begin
         int k;
         k = $urandom_range(1, 5);
         for (int i = 0; i < k; i++)
            send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 1'b0, pd);
         status_check("rnd_status");
         for (int i = 0; i < $urandom_range(1, 5); i++) pop_check("rnd_data");
         csr(1'b0, 3'b001, STAT, 32'h0003_0000, rd, vl);
         m_ovr = 0; m_ferr = 0;
         status_check("rnd_cleared");
         while (q.size() != 0) pop_check("rnd_drain");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
